// File: rtl/bcd_sweep_ctrl_if.sv
// Sweep-control bundle: request/abort/endpoint inputs plus the BCD code,
// one-hot decimal select and status pulses returned by the controller.
interface bcd_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic       dir;
    logic [3:0] first;
    logic [3:0] last;
    logic [3:0] a;
    logic [9:0] dec;
    logic       busy;
    logic       done;
    logic       err;

    // Requester side: issues sweeps, observes the code and status.
    modport master (
        output start, abort, dir, first, last,
        input  a, dec, busy, done, err
    );

    // Controller side.
    modport slave (
        input  start, abort, dir, first, last,
        output a, dec, busy, done, err
    );
endinterface

// File: rtl/bcd_sweep_ctrl.sv
// BCD sweep controller: steps a BCD code from a start value to an end value
// (up or down, wrapping through 9/0), holding each code PRESCALE cycles and
// driving a registered one-hot decimal select alongside it.
module bcd_sweep_ctrl #(
    parameter int PRESCALE = 4
) (
    input  logic               clk,
    input  logic               rst,
    bcd_sweep_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Terminal count of the 8-bit hold counter; PRESCALE=256 maps to 255.
    localparam logic [7:0] TC = 8'(PRESCALE - 1);

    state_t     state_reg, state_next;
    logic [3:0] a_reg, a_next;
    logic [9:0] dec_reg, dec_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       err_reg, err_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       dir_reg, dir_next;
    logic [3:0] last_reg, last_next;

    // The start value needs no separate copy: it is loaded straight into a_reg.
    logic [3:0] a_step;
    logic [9:0] first_onehot;
    logic [9:0] step_onehot;

    // Next code in the sweep direction, wrapping 9->0 going up and 0->9 going down.
    always_comb begin
        if (dir_reg)
            a_step = (a_reg == 4'd0) ? 4'd9 : a_reg - 4'd1;
        else
            a_step = (a_reg == 4'd9) ? 4'd0 : a_reg + 4'd1;
    end

    // Decimal decode of the two codes that can be loaded into a_reg.
    for (genvar gi = 0; gi < 10; gi++) begin : g_decode
        assign first_onehot[gi] = (bus.first == 4'(gi));
        assign step_onehot[gi]  = (a_step == 4'(gi));
    end

    // State and output registers; reset takes effect without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= 4'd0;
            dec_reg   <= 10'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            cnt_reg   <= 8'd0;
            dir_reg   <= 1'b0;
            last_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            dec_reg   <= dec_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
            last_reg  <= last_next;
        end
    end

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        dec_next   = dec_reg;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                dec_next = 10'd0;
                cnt_next = 8'd0;
                // Abort in the same cycle suppresses the request entirely.
                if (bus.start && !bus.abort) begin
                    if (bus.first <= 4'd9 && bus.last <= 4'd9) begin
                        state_next = RUN;
                        a_next     = bus.first;
                        dec_next   = first_onehot;
                        busy_next  = 1'b1;
                        dir_next   = bus.dir;
                        last_next  = bus.last;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_next = IDLE;
                    dec_next   = 10'd0;
                    cnt_next   = 8'd0;
                end else if (cnt_reg == TC) begin
                    cnt_next = 8'd0;
                    if (a_reg == last_reg) begin
                        // Final code has had its full hold time; a and dec stay put.
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        a_next    = a_step;
                        dec_next  = step_onehot;
                        busy_next = 1'b1;
                    end
                end else begin
                    cnt_next  = cnt_reg + 8'd1;
                    busy_next = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                dec_next   = 10'd0;
            end
            default: begin
                state_next = IDLE;
                dec_next   = 10'd0;
            end
        endcase
    end

    assign bus.a    = a_reg;
    assign bus.dec  = dec_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.err  = err_reg;
endmodule

// File: tb/tb_bcd_sweep_ctrl.sv
// Self-checking bench for bcd_sweep_ctrl (PRESCALE=2): directed vector table,
// hand-written reset/abort corners, then randomized sweeps against a model
// that lists the expected code sequence directly from the sweep rules.
module tb_bcd_sweep_ctrl;
    localparam int PRESCALE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] cur_a = 4'd0;   // model of the code a should be holding

    bcd_sweep_ctrl_if bus();

    bcd_sweep_ctrl #(.PRESCALE(PRESCALE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dir;
        logic [3:0] first;
        logic [3:0] last;
        int         abort_at;      // RUN cycle index that raises abort, -1 for none
        bit         start_in_run;  // keep start high while the sweep runs
        int         exp_busy;      // expected busy cycles, -1 for a rejected start
        logic [3:0] exp_end_a;     // code held once the sweep is over
    } vec_t;

    // Packed view of all outputs: {a, dec, busy, done, err}.
    function automatic logic [16:0] outs();
        return {bus.a, bus.dec, bus.busy, bus.done, bus.err};
    endfunction

    function automatic logic [9:0] onehot(input int v);
        logic [9:0] r;
        for (int n = 0; n < 10; n++) r[n] = (n == v);
        return r;
    endfunction

    task automatic chk(input string name, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got a=%0d dec=%b busy=%b done=%b err=%b, required a=%0d dec=%b busy=%b done=%b err=%b",
                     name, got[16:13], got[12:3], got[2], got[1], got[0],
                     exp[16:13], exp[12:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Issues one sweep from a falling edge and checks every following cycle.
    task automatic run_sweep(input logic d, input logic [3:0] f, input logic [3:0] l,
                             input int abort_at, input bit start_in_run,
                             input int exp_busy, input int exp_end_a);
        int  q[$];
        int  v;
        int  nbusy = 0;
        bit  aborted = 1'b0;
        bus.start = 1'b1; bus.abort = 1'b0;
        bus.dir = d; bus.first = f; bus.last = l;
        @(negedge clk);
        bus.start = start_in_run;
        if (f > 4'd9 || l > 4'd9) begin
            chk("err_pulse", outs(), {cur_a, 10'd0, 3'b001});
            bus.start = 1'b0;
            @(negedge clk);
            chk("err_clear", outs(), {cur_a, 10'd0, 3'b000});
            return;
        end
        // Expected codes: walk from first toward last modulo 10, each held PRESCALE cycles.
        v = int'(f);
        for (int k = 0; k < 10; k++) begin
            repeat (PRESCALE) q.push_back(v);
            if (v == int'(l)) break;
            v = d ? (v + 9) % 10 : (v + 1) % 10;
        end
        for (int i = 0; i < q.size(); i++) begin
            chk("run", outs(), {4'(q[i]), onehot(q[i]), 3'b100});
            if (bus.busy) nbusy++;
            if (i == abort_at) begin
                bus.abort = 1'b1;
                aborted   = 1'b1;
                cur_a     = 4'(q[i]);
            end
            @(negedge clk);
            if (aborted) break;
        end
        bus.start = 1'b0;
        if (aborted) begin
            chk("abort_idle", outs(), {cur_a, 10'd0, 3'b000});
            bus.abort = 1'b0;
        end else begin
            cur_a = l;
            chk("done", outs(), {cur_a, onehot(int'(l)), 3'b010});
            @(negedge clk);
            chk("idle_after_done", outs(), {cur_a, 10'd0, 3'b000});
        end
        if (exp_busy >= 0) begin
            chk_int("busy_cycles", nbusy, exp_busy);
            chk_int("end_code", int'(bus.a), exp_end_a);
        end
    endtask

    vec_t vecs[8];

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.dir = 1'b0;
        bus.first = 4'd0; bus.last = 4'd0;

        vecs[0] = '{1'b0, 4'd3,  4'd6, -1, 1'b0,  8, 4'd6};
        vecs[1] = '{1'b1, 4'd1,  4'd8, -1, 1'b0,  8, 4'd8};
        vecs[2] = '{1'b0, 4'hA,  4'd2, -1, 1'b0, -1, 4'd8};
        vecs[3] = '{1'b0, 4'd0,  4'd9,  4, 1'b0,  5, 4'd2};
        vecs[4] = '{1'b0, 4'd7,  4'd7, -1, 1'b1,  2, 4'd7};
        vecs[5] = '{1'b0, 4'd8,  4'd2, -1, 1'b0, 10, 4'd2};
        vecs[6] = '{1'b1, 4'd0,  4'd0, -1, 1'b0,  2, 4'd0};
        vecs[7] = '{1'b1, 4'd2,  4'd5, -1, 1'b1, 16, 4'd5};

        // Reset state.
        @(negedge clk);
        chk("reset_state", outs(), 17'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", outs(), 17'd0);

        for (int i = 0; i < 8; i++)
            run_sweep(vecs[i].dir, vecs[i].first, vecs[i].last, vecs[i].abort_at,
                      vecs[i].start_in_run, vecs[i].exp_busy, int'(vecs[i].exp_end_a));

        // start and abort together in IDLE: request dropped, no err.
        bus.start = 1'b1; bus.abort = 1'b1; bus.first = 4'd5; bus.last = 4'd6;
        @(negedge clk);
        chk("start_abort_same", outs(), {cur_a, 10'd0, 3'b000});
        bus.start = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        chk("start_abort_after", outs(), {cur_a, 10'd0, 3'b000});

        // Reset mid-sweep while a=4, then a start on the first edge after release.
        bus.start = 1'b1; bus.dir = 1'b0; bus.first = 4'd3; bus.last = 4'd8;
        @(negedge clk);
        bus.start = 1'b0;
        begin
            int n = 0;
            while (bus.a != 4'd4 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk_int("reach_a4", int'(bus.a), 4);
        end
        rst = 1'b1;
        #1;
        cur_a = 4'd0;
        chk("rst_async", outs(), 17'd0);
        @(negedge clk);
        chk("rst_held", outs(), 17'd0);
        rst = 1'b0;
        run_sweep(1'b0, 4'd0, 4'd1, -1, 1'b0, 4, 1);

        // Randomized sweeps, including illegal endpoints and occasional aborts.
        for (int r = 0; r < 30; r++) begin
            logic       d;
            logic [3:0] f;
            logic [3:0] l;
            int         ab;
            d  = 1'($urandom_range(0, 1));
            f  = 4'($urandom_range(0, 11));
            l  = 4'($urandom_range(0, 11));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
            run_sweep(d, f, l, ab, 1'($urandom_range(0, 1)), -1, 0);
            @(negedge clk);
            chk("random_gap_idle", outs(), {cur_a, 10'd0, 3'b000});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_sweep_ctrl.md
BCD_SWEEP_CTRL -- requirements
Module: bcd_sweep_ctrl

Interface
REQ-001 Parameter PRESCALE, default 4, clock cycles each BCD code is held during a sweep; legal range 1..256.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 abort  input  1  terminate a running sweep.
REQ-006 dir  input  1  0 = count up, 1 = count down; latched on accepted start.
REQ-007 first  input  4  BCD start value; latched on accepted start.
REQ-008 last  input  4  BCD end value; latched on accepted start.
REQ-009 a  output  4  current BCD code (a[3] MSB) fed to the BCD-to-decimal decode path.
REQ-010 dec  output  10  registered one-hot decimal select, bit n set when a == n.
REQ-011 busy  output  1  high while state is RUN.
REQ-012 done  output  1  one-cycle pulse on normal sweep completion.
REQ-013 err  output  1  one-cycle pulse on rejected start.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; all outputs registered.
REQ-015 IDLE: start=1, abort=0, first<=9, last<=9 -> RUN next cycle; a=first, dec=one-hot(first), busy=1, prescale counter=0.
REQ-016 IDLE: start=1 with first>9 or last>9 -> remain IDLE, err=1 next cycle for one cycle, a/dec unchanged.
REQ-017 IDLE: start=1 and abort=1 same cycle -> abort wins, start ignored, no err.
REQ-018 RUN: prescale counter increments each cycle; terminal count is PRESCALE-1, then it returns to 0.
REQ-019 RUN at terminal count, a != last: a steps (dir=0: +1, 9->0; dir=1: -1, 0->9), dec follows same cycle.
REQ-020 RUN at terminal count, a == last: -> DONE, a holds, busy=0, done=1.
REQ-021 Each code in a sweep SHALL be held exactly PRESCALE cycles; final code also held PRESCALE cycles before DONE.
REQ-022 first == last: single code held PRESCALE cycles, then DONE.
REQ-023 Sweeps wrap through 9/0 when the endpoint lies across the boundary (e.g. up 8->2: 8,9,0,1,2).
REQ-024 DONE lasts exactly one cycle, then IDLE; done=0 in IDLE.
REQ-025 IDLE: dec=0 (all bits low), a holds last driven value.
REQ-026 RUN: abort=1 -> IDLE next cycle, busy=0, dec=0, no done pulse, a holds.
REQ-027 start during RUN or DONE SHALL be ignored (no err, no restart).
REQ-028 a SHALL never carry a value above 9; dec SHALL be one-hot in RUN/DONE and zero in IDLE.
REQ-029 PRESCALE=1: code changes every cycle; counter logic SHALL be 8 bits wide.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, a=0, dec=0, busy=0, done=0, err=0, prescale counter=0, latched dir/first/last=0.
REQ-031 rst asserted mid-sweep SHALL abandon the sweep without done; after release block waits in IDLE for a new start.
REQ-032 start sampled during the first edge after rst deassertion SHALL be accepted normally.

Verification (bench PRESCALE=2)
REQ-033 start, dir=0, first=3, last=6 -> a=3,3,4,4,5,5,6,6 from next cycle, then done=1 one cycle with a=6, dec=0 in following IDLE.
REQ-034 start, dir=1, first=1, last=8 -> a=1,1,0,0,9,9,8,8 then done; dec[0] high only while a=0.
REQ-035 start with first=10 (4'hA), last=2 -> err pulse one cycle, busy stays 0, a/dec unchanged.
REQ-036 sweep 0->9 up, abort on 5th RUN cycle -> busy=0 next cycle, dec=0, a=2, no done.
REQ-037 first=last=7 -> a=7 for 2 cycles, done pulse; start asserted during RUN ignored.
REQ-038 rst pulsed during RUN with a=4 -> outputs zero immediately, no done; subsequent start first=0, last=1 completes normally.
